temp_alarm_monitor: RTL and testbench

- Multi-channel successor to the single two-bit temperature classifier: NCHAN sensor channels, each a 2-bit level code {T1,T2}.
- Per channel: debounce the code, then classify it as COLD/NORMAL/HOT/FAULT in a Moore state machine.
- FAULT is latched until acknowledged; saturating fault-event counter.
- Sits between the switch/sensor inputs and the LED/SEG drivers of the board top level.

---
 rtl/temp_mon_pkg.sv | 18 +
 rtl/temp_channel_fsm.sv | 68 ++++++
 rtl/temp_alarm_monitor.sv | 86 ++++++++
 tb/tb_temp_alarm_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/temp_mon_pkg.sv
// Shared types and code constants for the multi-channel temperature alarm monitor.
// The state encoding is identical to the 2-bit sensor level code {T1,T2}.
package temp_mon_pkg;

  typedef enum logic [1:0] {
    COLD   = 2'b00,
    FAULT  = 2'b01,
    NORMAL = 2'b10,
    HOT    = 2'b11
  } temp_state_t;

  localparam logic [1:0] CODE_COLD   = 2'b00;
  localparam logic [1:0] CODE_FAULT  = 2'b01;
  localparam logic [1:0] CODE_NORMAL = 2'b10;
  localparam logic [1:0] CODE_HOT    = 2'b11;
  localparam logic [1:0] CODE_RESET  = CODE_NORMAL;

endpackage

// File: rtl/temp_channel_fsm.sv
// One sensor channel: debounce of the 2-bit level code followed by a Moore
// classifier with a latched FAULT state and a combinational entry pulse.
module temp_channel_fsm
  import temp_mon_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] code,
  input  logic       ack,
  output logic       cold,
  output logic       hot,
  output logic       fault,
  output logic       entry
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);

  logic [1:0]    cand_p0, cand_nxt;
  logic [CW-1:0] cnt_p0, cnt_nxt;
  logic [1:0]    accepted_p1;
  temp_state_t   state_p2, state_nxt;

  always_comb begin
    cand_nxt = cand_p0;
    cnt_nxt  = cnt_p0;
    if (code == cand_p0) begin
      if (cnt_p0 != DEB_MAX) cnt_nxt = cnt_p0 + CW'(1);
    end else begin
      cand_nxt = code;
      cnt_nxt  = CW'(1);
    end
  end

  // A latched fault only releases on ack once the debounced code is no longer FAULT.
  always_comb begin
    state_nxt = state_p2;
    entry     = 1'b0;
    if (state_p2 != FAULT) begin
      state_nxt = temp_state_t'(accepted_p1);
      entry     = (accepted_p1 == CODE_FAULT);
    end else if (ack && (accepted_p1 != CODE_FAULT)) begin
      state_nxt = temp_state_t'(accepted_p1);
    end
  end

  // p0: candidate/count, p1: accepted code, p2: classifier state
  always_ff @(posedge clk_2) begin
    if (reset) begin
      cand_p0     <= CODE_RESET;
      cnt_p0      <= '0;
      accepted_p1 <= CODE_RESET;
      state_p2    <= NORMAL;
    end else begin
      cand_p0  <= cand_nxt;
      cnt_p0   <= cnt_nxt;
      if (cnt_nxt == DEB_MAX) accepted_p1 <= cand_nxt;
      state_p2 <= state_nxt;
    end
  end

  assign cold  = (state_p2 == COLD);
  assign hot   = (state_p2 == HOT);
  assign fault = (state_p2 == FAULT);

endmodule

// File: rtl/temp_alarm_monitor.sv
// NCHAN debounced temperature classifiers with a saturating fault-entry counter.
// Optional macro TEMP_BLINK_EN makes any_fault blink with half-period BLINK_DIV.
module temp_alarm_monitor
  import temp_mon_pkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int DEBOUNCE  = 3,
  parameter int CNT_W     = 8,
  parameter int BLINK_DIV = 4
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic [2*NCHAN-1:0] code_in,
  input  logic [NCHAN-1:0]   fault_ack,
  output logic [NCHAN-1:0]   cold,
  output logic [NCHAN-1:0]   hot,
  output logic [NCHAN-1:0]   fault,
  output logic               any_fault,
  output logic [CNT_W-1:0]   fault_count
);

  localparam int PW = $clog2(NCHAN + 1);
  localparam int SW = CNT_W + PW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NCHAN-1:0] entry;

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    temp_channel_fsm #(.DEBOUNCE(DEBOUNCE)) u_chan (
      .clk_2 (clk_2),
      .reset (reset),
      .code  (code_in[2*i+1:2*i]),
      .ack   (fault_ack[i]),
      .cold  (cold[i]),
      .hot   (hot[i]),
      .fault (fault[i]),
      .entry (entry[i])
    );
  end

  function automatic logic [PW-1:0] popcount(input logic [NCHAN-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < NCHAN; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0]    b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(CNT_MAX)) return CNT_MAX;
    return s[CNT_W-1:0];
  endfunction

  // p0: fault-entry count, updated on the same edge the channels enter FAULT
  always_ff @(posedge clk_2) begin
    if (reset) fault_count <= '0;
    else       fault_count <= sat_add(fault_count, popcount(entry));
  end

`ifdef TEMP_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_p0;
  logic          blink_phase_p0;

  // Divider restarts whenever no channel is faulted so each alarm starts lit.
  always_ff @(posedge clk_2) begin
    if (reset || !(|fault)) begin
      blink_cnt_p0   <= '0;
      blink_phase_p0 <= 1'b0;
    end else if (blink_cnt_p0 == BW'(BLINK_DIV - 1)) begin
      blink_cnt_p0   <= '0;
      blink_phase_p0 <= ~blink_phase_p0;
    end else begin
      blink_cnt_p0   <= blink_cnt_p0 + BW'(1);
    end
  end

  assign any_fault = (|fault) & ~blink_phase_p0;
`else
  assign any_fault = |fault;
`endif

endmodule

// File: tb/tb_temp_alarm_monitor.sv
// Randomized and directed bench for temp_alarm_monitor against a sample-history
// reference model (default build, TEMP_BLINK_EN undefined).
module tb_temp_alarm_monitor;

  localparam int NCH   = 4;
  localparam int DEB   = 3;
  localparam int CW    = 8;
  localparam int CMAX  = 255;

  logic               clk_2 = 1'b0;
  logic               reset;
  logic [2*NCH-1:0]   code_in;
  logic [NCH-1:0]     fault_ack;
  logic [NCH-1:0]     cold, hot, fault;
  logic               any_fault;
  logic [CW-1:0]      fault_count;

  temp_alarm_monitor #(.NCHAN(NCH), .DEBOUNCE(DEB), .CNT_W(CW), .BLINK_DIV(4)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .code_in     (code_in),
    .fault_ack   (fault_ack),
    .cold        (cold),
    .hot         (hot),
    .fault       (fault),
    .any_fault   (any_fault),
    .fault_count (fault_count)
  );

  always #5 clk_2 = ~clk_2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a code is accepted once the last DEB samples since reset agree;
  // the classifier reacts one edge later to the previously accepted code.
  logic [1:0] hist [NCH][DEB];
  int         nsamp [NCH];
  logic [1:0] m_acc [NCH];
  logic [1:0] m_state [NCH];
  int         m_count;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [2*NCH-1:0] c, input logic [NCH-1:0] a, input logic r);
    int entries;
    logic [1:0] smp;
    logic same;
    entries = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (r) begin
        nsamp[ch]   = 0;
        m_acc[ch]   = 2'b10;
        m_state[ch] = 2'b10;
      end else begin
        if (m_state[ch] != 2'b01) begin
          if (m_acc[ch] == 2'b01) entries++;
          m_state[ch] = m_acc[ch];
        end else if (a[ch] && m_acc[ch] != 2'b01) begin
          m_state[ch] = m_acc[ch];
        end
        smp = c[2*ch +: 2];
        for (int k = DEB - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = smp;
        if (nsamp[ch] < DEB) nsamp[ch]++;
        if (nsamp[ch] >= DEB) begin
          same = 1'b1;
          for (int k = 1; k < DEB; k++) if (hist[ch][k] != smp) same = 1'b0;
          if (same) m_acc[ch] = smp;
        end
      end
    end
    if (r) m_count = 0;
    else   m_count = (m_count + entries > CMAX) ? CMAX : m_count + entries;
  endtask

  task automatic step(input logic [2*NCH-1:0] c, input logic [NCH-1:0] a, input logic r);
    logic [NCH-1:0] ec, eh, ef;
    code_in   = c;
    fault_ack = a;
    reset     = r;
    @(posedge clk_2);
    model_edge(c, a, r);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      ec[ch] = (m_state[ch] == 2'b00);
      eh[ch] = (m_state[ch] == 2'b11);
      ef[ch] = (m_state[ch] == 2'b01);
    end
    check_val("cold", 32'(cold), 32'(ec));
    check_val("hot", 32'(hot), 32'(eh));
    check_val("fault", 32'(fault), 32'(ef));
    check_val("any_fault", 32'(any_fault), 32'(|ef));
    check_val("fault_count", 32'(fault_count), 32'(m_count));
  endtask

  initial begin
    int hold [NCH];
    logic [1:0] cur [NCH];
    logic [2*NCH-1:0] c;
    logic [NCH-1:0] a;

    for (int ch = 0; ch < NCH; ch++) begin
      nsamp[ch] = 0; m_acc[ch] = 2'b10; m_state[ch] = 2'b10;
      hold[ch] = 0; cur[ch] = 2'b10;
      for (int k = 0; k < DEB; k++) hist[ch][k] = 2'b10;
    end
    m_count = 0;

    // Reset, then all channels NORMAL
    step(8'hAA, 4'h0, 1'b1);
    step(8'hAA, 4'h0, 1'b1);
    check_val("reset_count", 32'(fault_count), 32'd0);
    for (int i = 0; i < 8; i++) step(8'hAA, 4'h0, 1'b0);

    // Ch0 glitch of 2 cycles must not reach the classifier, then held HOT
    step(8'hAB, 4'h0, 1'b0);
    step(8'hAB, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'hAA, 4'h0, 1'b0);
    check_val("glitch_hot0", 32'(hot[0]), 32'd0);
    step(8'hAB, 4'h0, 1'b0);
    step(8'hAB, 4'h0, 1'b0);
    step(8'hAB, 4'h0, 1'b0);
    check_val("hot0_early", 32'(hot[0]), 32'd0);
    step(8'hAB, 4'h0, 1'b0);
    check_val("hot0_set", 32'(hot[0]), 32'd1);
    for (int i = 0; i < 3; i++) step(8'hAB, 4'h0, 1'b0);

    // Ch1 FAULT for 3 cycles then NORMAL without ack: latched
    for (int i = 0; i < 3; i++) step(8'hA6, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(8'hAA, 4'h0, 1'b0);
    check_val("fault1_latched", 32'(fault[1]), 32'd1);
    check_val("count_one", 32'(fault_count), 32'd1);
    step(8'hAA, 4'h2, 1'b0);
    check_val("fault1_cleared", 32'(fault[1]), 32'd0);
    for (int i = 0; i < 3; i++) step(8'hAA, 4'h0, 1'b0);

    // Ch2 and ch3 enter FAULT together; ack on ch2 while still faulted
    for (int i = 0; i < 4; i++) step(8'h5A, 4'h0, 1'b0);
    check_val("count_three", 32'(fault_count), 32'd3);
    for (int i = 0; i < 4; i++) step(8'h5A, 4'h4, 1'b0);
    check_val("fault2_held", 32'(fault[2]), 32'd1);
    check_val("count_hold", 32'(fault_count), 32'd3);
    for (int i = 0; i < 5; i++) step(8'hAA, 4'hC, 1'b0);

    // Saturation: repeated ch0 entries
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 4; i++) step(8'hA9, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) step(8'hAA, 4'h1, 1'b0);
    end
    check_val("sat_hold", 32'(fault_count), 32'hFF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (hold[ch] == 0) begin
          cur[ch]  = 2'($urandom_range(0, 3));
          hold[ch] = $urandom_range(1, 5);
        end
        hold[ch]--;
        c[2*ch +: 2] = cur[ch];
        a[ch] = ($urandom_range(0, 5) == 0);
      end
      step(c, a, $urandom_range(0, 299) == 0);
    end

    // Reset with ch0 mid-debounce and ch1 in FAULT
    for (int i = 0; i < 5; i++) step(8'hA6, 4'h0, 1'b0);
    step(8'hA7, 4'h0, 1'b0);
    step(8'hA7, 4'h3, 1'b1);
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_hot", 32'(hot), 32'd0);
    check_val("rst_cold", 32'(cold), 32'd0);
    check_val("rst_count", 32'(fault_count), 32'd0);
    for (int i = 0; i < 6; i++) step(8'hA7, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
